// File: rtl/pm_ctrl_slave.sv
// Pixel-matrix receiver of the PMC control bus: oversamples the bus, decodes shift/store/strobe/res.
// Define PM_CTRL_SLAVE_SYNC_EN to insert a 2-flop synchronizer ahead of the input register stage.
module pm_ctrl_slave #(
    parameter int SHIFT_LEN = 16,
    parameter int NUM_COLS  = 10,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_COLS-1:0]       res,
    input  logic                      store,
    input  logic                      strobe,
    input  logic                      gate,
    input  logic                      sh_a,
    input  logic                      sh_b,
    input  logic                      clk_sh,
    output logic [SHIFT_LEN-1:0]      cfg_a,
    output logic [SHIFT_LEN-1:0]      cfg_b,
    output logic                      cfg_upd,
    output logic                      sh_out_a,
    output logic                      sh_out_b,
    output logic [NUM_COLS*CNT_W-1:0] cnt,
    output logic [NUM_COLS-1:0]       sat
);

    localparam int IN_W = NUM_COLS + 6;

    generate
        if (SHIFT_LEN < NUM_COLS || NUM_COLS != 10) begin : g_bad_param
            $error("pm_ctrl_slave: need SHIFT_LEN >= NUM_COLS and NUM_COLS == 10");
        end
    endgenerate

    logic [IN_W-1:0] w_in_raw;
    logic [IN_W-1:0] w_in_pre;
    logic [IN_W-1:0] r_in_q;
    logic [2:0]      r_edge_qq;

    // Bus packed as {res, store, strobe, gate, sh_a, sh_b, clk_sh}
    assign w_in_raw = {res, store, strobe, gate, sh_a, sh_b, clk_sh};

`ifdef PM_CTRL_SLAVE_SYNC_EN
    logic [IN_W-1:0] r_sync1;
    logic [IN_W-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_in_raw;
            r_sync2 <= r_sync1;
        end
    end
    assign w_in_pre = r_sync2;
`else
    assign w_in_pre = w_in_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q    <= '0;
            r_edge_qq <= '0;
        end else begin
            r_in_q    <= w_in_pre;
            r_edge_qq <= {r_in_q[5], r_in_q[4], r_in_q[0]};
        end
    end

    logic                w_sh_edge;
    logic                w_strobe_edge;
    logic                w_store_edge;
    logic                w_gate_q;
    logic                w_sh_a_q;
    logic                w_sh_b_q;
    logic [NUM_COLS-1:0] w_res_q;

    assign w_sh_edge     = r_in_q[0] & ~r_edge_qq[0];
    assign w_strobe_edge = r_in_q[4] & ~r_edge_qq[1];
    assign w_store_edge  = r_in_q[5] & ~r_edge_qq[2];
    assign w_sh_b_q      = r_in_q[1];
    assign w_sh_a_q      = r_in_q[2];
    assign w_gate_q      = r_in_q[3];
    assign w_res_q       = r_in_q[IN_W-1:6];

    logic [SHIFT_LEN-1:0] r_chain_a;
    logic [SHIFT_LEN-1:0] r_chain_b;
    logic [SHIFT_LEN-1:0] r_cfg_a;
    logic [SHIFT_LEN-1:0] r_cfg_b;
    logic                 r_cfg_upd;

    // A coincident store captures the chain before this cycle's shift (NBA ordering)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain_a <= '0;
            r_chain_b <= '0;
            r_cfg_a   <= '0;
            r_cfg_b   <= '0;
            r_cfg_upd <= 1'b0;
        end else begin
            r_cfg_upd <= w_store_edge;
            if (w_sh_edge) begin
                r_chain_a <= {r_chain_a[SHIFT_LEN-2:0], w_sh_a_q};
                r_chain_b <= {r_chain_b[SHIFT_LEN-2:0], w_sh_b_q};
            end
            if (w_store_edge) begin
                r_cfg_a <= r_chain_a;
                r_cfg_b <= r_chain_b;
            end
        end
    end

    assign cfg_a    = r_cfg_a;
    assign cfg_b    = r_cfg_b;
    assign cfg_upd  = r_cfg_upd;
    assign sh_out_a = r_chain_a[SHIFT_LEN-1];
    assign sh_out_b = r_chain_b[SHIFT_LEN-1];

    logic w_count_en;
    assign w_count_en = w_strobe_edge & w_gate_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
            logic [CNT_W-1:0] r_cnt;
            logic             r_sat;

            // Column clear dominates; enable comes from cfg_a before any same-cycle store
            always_ff @(posedge clk) begin
                if (rst || w_res_q[gi]) begin
                    r_cnt <= '0;
                    r_sat <= 1'b0;
                end else if (w_count_en && r_cfg_a[gi]) begin
                    if (r_cnt == {CNT_W{1'b1}}) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign cnt[gi*CNT_W +: CNT_W] = r_cnt;
            assign sat[gi]                = r_sat;
        end
    endgenerate

endmodule

// File: tb/tb_pm_ctrl_slave.sv
// Directed bench for pm_ctrl_slave with a cycle-level reference model and literal spot checks.
// Honours PM_CTRL_SLAVE_SYNC_EN for the model's input latency.
module tb_pm_ctrl_slave;
    localparam int SL = 16;
    localparam int NC = 10;
    localparam int CW = 4;
`ifdef PM_CTRL_SLAVE_SYNC_EN
    localparam int D = 3;
`else
    localparam int D = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0] res;
    logic store, strobe, gate, sh_a, sh_b, clk_sh;
    logic [SL-1:0] cfg_a, cfg_b;
    logic cfg_upd, sh_out_a, sh_out_b;
    logic [NC*CW-1:0] cnt;
    logic [NC-1:0] sat;

    pm_ctrl_slave #(.SHIFT_LEN(SL), .NUM_COLS(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .res(res), .store(store), .strobe(strobe), .gate(gate),
        .sh_a(sh_a), .sh_b(sh_b), .clk_sh(clk_sh), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_upd(cfg_upd), .sh_out_a(sh_out_a), .sh_out_b(sh_out_b), .cnt(cnt), .sat(sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;
    int upd_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
            end
        end
    endtask

    // Reference model: bus history plus decoded state, stepped once per clock
    logic [15:0] hist [0:4];
    logic [SL-1:0] m_chain_a = '0, m_chain_b = '0, m_cfg_a = '0, m_cfg_b = '0;
    bit m_upd = 0;
    int m_cnt [NC];
    bit m_sat [NC];

    initial begin
        logic [15:0] cur, prv;
        for (int k = 0; k < 5; k++) hist[k] = '0;
        for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_sat[c] = 0; end
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 5; k++) hist[k] = '0;
                m_chain_a = '0; m_chain_b = '0; m_cfg_a = '0; m_cfg_b = '0; m_upd = 0;
                for (int c = 0; c < NC; c++) begin m_cnt[c] = 0; m_sat[c] = 0; end
            end else begin
                for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = {res, store, strobe, gate, sh_a, sh_b, clk_sh};
                cur = hist[D];
                prv = hist[D+1];
                for (int c = 0; c < NC; c++) begin
                    if (cur[6+c]) begin
                        m_cnt[c] = 0;
                        m_sat[c] = 0;
                    end else if (cur[4] && !prv[4] && cur[3] && m_cfg_a[c]) begin
                        if (m_cnt[c] == (1 << CW) - 1) m_sat[c] = 1;
                        else m_cnt[c] = m_cnt[c] + 1;
                    end
                end
                m_upd = cur[5] && !prv[5];
                if (m_upd) begin
                    m_cfg_a = m_chain_a;
                    m_cfg_b = m_chain_b;
                end
                if (cur[0] && !prv[0]) begin
                    m_chain_a = {m_chain_a[SL-2:0], cur[2]};
                    m_chain_b = {m_chain_b[SL-2:0], cur[1]};
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [NC*CW-1:0] e_cnt;
        logic [NC-1:0] e_sat;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                e_cnt[c*CW +: CW] = m_cnt[c][CW-1:0];
                e_sat[c] = m_sat[c];
            end
            if (cfg_upd === 1'b1) upd_count++;
            chk("cfg_a", 64'(cfg_a), 64'(m_cfg_a));
            chk("cfg_b", 64'(cfg_b), 64'(m_cfg_b));
            chk("cfg_upd", 64'(cfg_upd), 64'(m_upd));
            chk("sh_out_a", 64'(sh_out_a), 64'(m_chain_a[SL-1]));
            chk("sh_out_b", 64'(sh_out_b), 64'(m_chain_b[SL-1]));
            chk("cnt", 64'(cnt), 64'(e_cnt));
            chk("sat", 64'(sat), 64'(e_sat));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [15:0] wa, input logic [15:0] wb, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) begin
            sh_a = wa[i];
            sh_b = wb[i];
            cyc(1);
            clk_sh = 1'b1;
            cyc(2);
            clk_sh = 1'b0;
            cyc(1);
        end
    endtask

    task automatic do_store();
        store = 1'b1;
        cyc(2);
        store = 1'b0;
        cyc(2);
    endtask

    task automatic load(input logic [15:0] wa, input logic [15:0] wb);
        shift_bits(wa, wb, 16);
        do_store();
        cyc(4);
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            strobe = 1'b1;
            cyc(2);
            strobe = 1'b0;
            cyc(2);
        end
    endtask

    initial begin
        rst = 1'b1; res = '0; store = 0; strobe = 0; gate = 0; sh_a = 0; sh_b = 0; clk_sh = 0;
        cyc(3);
        chk("reset_cfg_a", 64'(cfg_a), 64'h0);
        chk("reset_cnt", 64'(cnt), 64'h0);
        chk("reset_sat", 64'(sat), 64'h0);
        chk("reset_upd", 64'(cfg_upd), 64'h0);
        rst = 1'b0;
        cyc(2);

        // Shift and store two words
        upd_count = 0;
        load(16'hA5C3, 16'h0F0F);
        chk("t1_cfg_a", 64'(cfg_a), 64'hA5C3);
        chk("t1_cfg_b", 64'(cfg_b), 64'h0F0F);
        chk("t1_upd_pulses", 64'(upd_count), 64'd1);

        // Gated counting on columns 0 and 1, then ungated strobes ignored
        load(16'h0003, 16'h0000);
        gate = 1'b1;
        cyc(1);
        strobes(5);
        cyc(4);
        chk("t2_cnt0", 64'(cnt[3:0]), 64'd5);
        chk("t2_cnt1", 64'(cnt[7:4]), 64'd5);
        chk("t2_cnt_rest", 64'(cnt[NC*CW-1:8]), 64'd0);
        gate = 1'b0;
        cyc(1);
        strobes(3);
        cyc(4);
        chk("t2_cnt0_hold", 64'(cnt[3:0]), 64'd5);
        chk("t2_cnt1_hold", 64'(cnt[7:4]), 64'd5);

        // Saturation then single-cycle clear
        load(16'h0001, 16'h0000);
        res = '1;
        cyc(2);
        res = '0;
        cyc(1);
        gate = 1'b1;
        strobes(17);
        cyc(4);
        chk("t3_cnt0_sat", 64'(cnt[3:0]), 64'd15);
        chk("t3_sat0", 64'(sat[0]), 64'd1);
        res[0] = 1'b1;
        cyc(1);
        res = '0;
        cyc(5);
        chk("t3_cnt0_clr", 64'(cnt[3:0]), 64'd0);
        chk("t3_sat0_clr", 64'(sat[0]), 64'd0);

        // Held column clear blocks counting on column 1 only
        load(16'h0003, 16'h0000);
        res = '1;
        cyc(2);
        res = 10'b00_0000_0010;
        cyc(1);
        strobes(4);
        cyc(4);
        chk("t4_cnt0", 64'(cnt[3:0]), 64'd4);
        chk("t4_cnt1", 64'(cnt[7:4]), 64'd0);
        res = '0;
        cyc(2);

        // Gate drops while the strobe edge is being decoded: still counts
        strobe = 1'b1;
        cyc(1);
        gate = 1'b0;
        cyc(1);
        strobe = 1'b0;
        cyc(6);
        chk("gate_fall_cnt0", 64'(cnt[3:0]), 64'd5);
        chk("gate_fall_cnt1", 64'(cnt[7:4]), 64'd1);

        // Store and shift edges coincide
        shift_bits(16'h8001, 16'h0000, 16);
        sh_a = 1'b1;
        cyc(1);
        store = 1'b1;
        clk_sh = 1'b1;
        cyc(2);
        store = 1'b0;
        clk_sh = 1'b0;
        cyc(4);
        chk("t5_cfg_a", 64'(cfg_a), 64'h8001);
        chk("t5_sh_out_a", 64'(sh_out_a), 64'd0);
        do_store();
        cyc(4);
        chk("t5_chain_a", 64'(cfg_a), 64'h0003);

        // Reset partway through a shift sequence
        shift_bits(16'hA5C3, 16'h0F0F, 7);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        upd_count = 0;
        do_store();
        cyc(4);
        chk("t6_cfg_a", 64'(cfg_a), 64'h0);
        chk("t6_upd_pulses", 64'(upd_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
